// File: rtl/leaf_controller_if.sv
// Handshake bundle between the leaf controller and its surroundings.
// Ports (signals):
//   rx_data/rx_valid/rx_ready       command words from the root hub (down link)
//   tx_data/tx_valid/tx_ready       result word to the root hub (up link)
//   meas_data/meas_valid/meas_ready measurement payload toward the decoder
//   dec_start/dec_done/dec_iterations decoder launch and completion
//   busy                            controller is not idle
// Modports: slave = the controller's view, master = the hub/decoder view.
interface leaf_controller_if #(
  parameter int CHANNEL_WIDTH = 64
);
  logic [CHANNEL_WIDTH-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic [CHANNEL_WIDTH-1:0] tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [CHANNEL_WIDTH-1:0] meas_data;
  logic                     meas_valid;
  logic                     meas_ready;
  logic                     dec_start;
  logic                     dec_done;
  logic [7:0]               dec_iterations;
  logic                     busy;

  modport slave (
    input  rx_data, rx_valid, tx_ready, meas_ready, dec_done, dec_iterations,
    output rx_ready, tx_data, tx_valid, meas_data, meas_valid, dec_start, busy
  );

  modport master (
    output rx_data, rx_valid, tx_ready, meas_ready, dec_done, dec_iterations,
    input  rx_ready, tx_data, tx_valid, meas_data, meas_valid, dec_start, busy
  );
endinterface

// File: rtl/leaf_controller.sv
// Leaf endpoint of the root-hub message network. Accepts a start command and a
// measurement header, streams the payload into the decoder, launches and times
// one decode, and returns a result word {8'h00, FPGA_ID, iter, cycles, 24'h0}.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset (aborts any operation, no result)
//   bus    leaf_controller_if.slave (rx / tx / meas / dec handshakes, busy)
//
// state    | meaning
// IDLE     | waiting for START_DECODING_MSG, other words dropped
// WAIT_HDR | waiting for MEASUREMENT_DATA_HEADER
// LOAD     | payload pass-through rx -> meas, rem words left
// START    | one-cycle dec_start pulse, cycle counter cleared
// RUN      | decoder running, cycles counted, rx back-pressured
// REPORT   | result word offered upstream
module leaf_controller #(
  parameter int         FPGA_ID                 = 1,
  parameter int         CHANNEL_WIDTH           = 64,
  parameter int         CNT_WIDTH               = 16,
  parameter logic [7:0] START_DECODING_MSG      = 8'h01,
  parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02
) (
  input logic              clk,
  input logic              reset,
  leaf_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT_HDR, LOAD, START, RUN, REPORT} state_t;

  localparam logic [7:0]           ID8     = 8'(FPGA_ID);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state, state_nxt;
  logic                 multi;
  logic [15:0]          rem;
  logic [CNT_WIDTH-1:0] cnt;
  logic [7:0]           iter;
  logic                 rx_ready_c;
  logic                 rx_fire;
  logic [7:0]           rx_type;
  logic                 report_en;

  assign rx_fire   = bus.rx_valid & rx_ready_c;
  assign rx_type   = bus.rx_data[47:40];
  // A multi-FPGA decode is reported only by the primary leaf.
  assign report_en = !multi || (FPGA_ID == 1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rx_fire && rx_type == START_DECODING_MSG) state_nxt = WAIT_HDR;
      WAIT_HDR: if (rx_fire && rx_type == MEASUREMENT_DATA_HEADER)
                  state_nxt = (bus.rx_data[15:0] != 16'd0) ? LOAD : START;
      LOAD:     if (rx_fire && rem == 16'd1) state_nxt = START;
      START:    state_nxt = RUN;
      RUN:      if (bus.dec_done) state_nxt = report_en ? REPORT : IDLE;
      REPORT:   if (bus.tx_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready_c     = 1'b0;
    bus.meas_data  = '0;
    bus.meas_valid = 1'b0;
    bus.tx_data    = '0;
    bus.tx_valid   = 1'b0;
    bus.dec_start  = 1'b0;
    bus.busy       = 1'b1;
    case (state)
      IDLE: begin
        rx_ready_c = 1'b1;
        bus.busy   = 1'b0;
      end
      WAIT_HDR: rx_ready_c = 1'b1;
      LOAD: begin
        bus.meas_data  = bus.rx_data;
        bus.meas_valid = bus.rx_valid;
        rx_ready_c     = bus.meas_ready;
      end
      START:  bus.dec_start = 1'b1;
      REPORT: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = {8'h00, ID8, iter, cnt, 24'h0};
      end
      default: ;
    endcase
  end

  assign bus.rx_ready = rx_ready_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      multi <= 1'b0;
      rem   <= '0;
      cnt   <= '0;
      iter  <= '0;
    end else begin
      case (state)
        IDLE: if (rx_fire && rx_type == START_DECODING_MSG) multi <= bus.rx_data[0];
        WAIT_HDR: begin
          if (rx_fire && rx_type == START_DECODING_MSG)      multi <= bus.rx_data[0];
          if (rx_fire && rx_type == MEASUREMENT_DATA_HEADER) rem   <= bus.rx_data[15:0];
        end
        LOAD:  if (rx_fire) rem <= rem - 16'd1;
        START: cnt <= '0;
        RUN: begin
          // The dec_done cycle is itself counted, so done on the first RUN
          // cycle reports 1.
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (bus.dec_done)   iter <= bus.dec_iterations;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_controller.sv
// Randomized bench for leaf_controller: a transaction-level reference model
// predicts payload order, dec_start timing and the result word.
module tb_leaf_controller;

  localparam logic [7:0] T_START = 8'h01;
  localparam logic [7:0] T_HDR   = 8'h02;
  localparam logic [7:0] T_JUNK  = 8'h7E;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leaf_controller_if #(.CHANNEL_WIDTH(64)) b1 ();
  leaf_controller_if #(.CHANNEL_WIDTH(64)) b2 ();

  leaf_controller #(
    .FPGA_ID(1), .CHANNEL_WIDTH(64), .CNT_WIDTH(16),
    .START_DECODING_MSG(T_START), .MEASUREMENT_DATA_HEADER(T_HDR)
  ) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  leaf_controller #(
    .FPGA_ID(2), .CHANNEL_WIDTH(64), .CNT_WIDTH(16),
    .START_DECODING_MSG(T_START), .MEASUREMENT_DATA_HEADER(T_HDR)
  ) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int last_rx_cyc = 0;
  int rdy_mode = 0;
  bit tog = 1'b1;
  logic [63:0] meas_q[$];
  logic [63:0] tx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b1.meas_valid && b1.meas_ready) meas_q.push_back(b1.meas_data);
    if (b1.rx_valid && b1.rx_ready) last_rx_cyc <= cyc;
    if (b1.dec_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (b1.tx_valid && b1.tx_ready) tx_q.push_back(b1.tx_data);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Reference model: result word and whether this leaf reports at all.
  function automatic logic [63:0] model_result(input int id, input logic [7:0] it, input int len);
    int cycles;
    cycles = (len > 65535) ? 65535 : len;
    return {8'h00, 8'(id), it, 16'(cycles), 24'h0};
  endfunction

  function automatic bit model_reports(input int id, input bit multi);
    return !multi || (id == 1);
  endfunction

  function automatic logic [63:0] mk(input logic [7:0] typ, input logic [15:0] low);
    logic [23:0] mid;
    mid = 24'($urandom);
    return {8'h02, 8'h00, typ, mid, low};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mready;
    case (rdy_mode)
      0:       b1.meas_ready = 1'b1;
      1: begin b1.meas_ready = tog; tog = ~tog; end
      default: b1.meas_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send(input logic [63:0] w);
    bit done;
    done = 1'b0;
    b1.rx_data  = w;
    b1.rx_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      set_mready();
      @(negedge clk);
      done = b1.rx_ready;
      @(posedge clk);
      #1;
    end
    b1.rx_valid = 1'b0;
    b1.rx_data  = '0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_txn(input bit multi, input int n, input int len, input logic [7:0] it,
                         input int stall, input bit offer_rx, input int mode, input bit junk);
    logic [63:0] exp_meas[$];
    logic [63:0] w, exp_tx;
    int s0, rx_snap;
    bit rep;
    meas_q.delete();
    tx_q.delete();
    s0 = start_cnt;
    rdy_mode = 0;
    send(mk(T_START, {15'($urandom), multi}));
    if (junk) begin
      send(mk(T_JUNK, 16'($urandom)));
      @(negedge clk);
      chk("junk_wait_hdr_busy", b1.busy, 1);
      tick;
    end
    send(mk(T_HDR, 16'(n)));
    rdy_mode = mode;
    tog = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      exp_meas.push_back(w);
      send(w);
    end
    b1.meas_ready = 1'b0;
    rx_snap = last_rx_cyc;
    @(negedge clk);
    chk("dec_start", b1.dec_start, 1);
    tick;
    if (len > 1) begin
      @(negedge clk);
      chk("busy_run", b1.busy, 1);
      chk("rx_ready_run", b1.rx_ready, 0);
      chk("dec_start_once", b1.dec_start, 0);
      @(posedge clk);
      #1;
      repeat (len - 2) tick;
    end
    b1.dec_done = 1'b1;
    b1.dec_iterations = it;
    tick;
    b1.dec_done = 1'b0;
    b1.dec_iterations = 8'($urandom);
    rep = model_reports(1, multi);
    exp_tx = model_result(1, it, len);
    @(negedge clk);
    if (rep) begin
      chk("tx_valid", b1.tx_valid, 1);
      chk("tx_data", b1.tx_data, exp_tx);
      chk("rx_ready_report", b1.rx_ready, 0);
      if (offer_rx) begin
        b1.rx_data  = mk(T_JUNK, 16'($urandom));
        b1.rx_valid = 1'b1;
      end
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("tx_hold_data", b1.tx_data, exp_tx);
        chk("tx_hold_valid", b1.tx_valid, 1);
        chk("rx_ready_stall", b1.rx_ready, 0);
      end
      @(posedge clk);
      #1;
      b1.tx_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      b1.tx_ready = 1'b0;
      @(negedge clk);
      chk("idle_after_tx", b1.busy, 0);
      chk("tx_valid_idle", b1.tx_valid, 0);
      if (offer_rx) chk("rx_accept_idle", b1.rx_ready, 1);
      @(posedge clk);
      #1;
      b1.rx_valid = 1'b0;
    end else begin
      chk("tx_suppressed", b1.tx_valid, 0);
      chk("idle_suppressed", b1.busy, 0);
      tick;
    end
    @(negedge clk);
    chk("idle_end", b1.busy, 0);
    chk("meas_count", meas_q.size(), exp_meas.size());
    for (int i = 0; i < exp_meas.size() && i < meas_q.size(); i++)
      chk("meas_word", meas_q[i], exp_meas[i]);
    chk("start_count", start_cnt - s0, 1);
    chk("start_latency", start_cyc, rx_snap + 1);
    chk("tx_count", tx_q.size(), rep ? 1 : 0);
    if (rep && tx_q.size() > 0) chk("tx_word", tx_q[0], exp_tx);
    tick;
  endtask

  initial begin
    reset = 1'b1;
    b1.rx_data = '0; b1.rx_valid = 1'b0; b1.tx_ready = 1'b0; b1.meas_ready = 1'b0;
    b1.dec_done = 1'b0; b1.dec_iterations = '0;
    b2.rx_data = '0; b2.rx_valid = 1'b0; b2.tx_ready = 1'b0; b2.meas_ready = 1'b0;
    b2.dec_done = 1'b0; b2.dec_iterations = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx_valid", b1.tx_valid, 0);
    chk("rst_meas_valid", b1.meas_valid, 0);
    chk("rst_dec_start", b1.dec_start, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_rx_ready", b1.rx_ready, 1);
    chk("rst_tx_data", b1.tx_data, 0);
    tick;

    // Unknown type in IDLE is consumed without leaving IDLE.
    send(mk(T_JUNK, 16'h1234));
    @(negedge clk);
    chk("junk_idle_busy", b1.busy, 0);
    chk("junk_idle_meas", b1.meas_valid, 0);
    tick;

    run_txn(1'b0, 0, 10, 8'h03, 0, 1'b0, 0, 1'b0);
    if (tx_q.size() == 1) chk("t2_word", tx_q[0], 64'h0001_0300_0A00_0000);
    run_txn(1'b0, 3, 5, 8'h21, 1, 1'b0, 1, 1'b0);
    run_txn(1'b1, 2, 4, 8'h44, 0, 1'b0, 2, 1'b0);
    run_txn(1'b0, 1, 3, 8'h55, 5, 1'b1, 0, 1'b0);
    run_txn(1'b0, 0, 1, 8'h66, 0, 1'b0, 0, 1'b1);

    // Non-primary leaf with multi set: decode runs, no result.
    @(negedge clk);
    chk("d2_rx_ready", b2.rx_ready, 1);
    @(posedge clk);
    #1;
    b2.rx_data = mk(T_START, 16'h0001);
    b2.rx_valid = 1'b1;
    tick;
    b2.rx_data = mk(T_HDR, 16'h0000);
    tick;
    b2.rx_valid = 1'b0;
    @(negedge clk);
    chk("d2_dec_start", b2.dec_start, 1);
    tick;
    repeat (3) tick;
    b2.dec_done = 1'b1;
    b2.dec_iterations = 8'h09;
    tick;
    b2.dec_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("d2_no_tx", b2.tx_valid, 0);
      chk("d2_idle", b2.busy, 0);
      tick;
    end

    for (int t = 0; t < 20; t++)
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(1, 40),
              8'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    // Reset in the middle of RUN aborts without a result.
    tx_q.delete();
    rdy_mode = 0;
    send(mk(T_START, 16'h0000));
    send(mk(T_HDR, 16'd2));
    send({$urandom, $urandom});
    send({$urandom, $urandom});
    @(negedge clk);
    chk("abort_dec_start", b1.dec_start, 1);
    tick;
    repeat (3) tick;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", b1.busy, 0);
    chk("abort_tx_valid", b1.tx_valid, 0);
    chk("abort_rx_ready", b1.rx_ready, 1);
    @(posedge clk);
    #1;
    b1.dec_done = 1'b1;
    tick;
    b1.dec_done = 1'b0;
    @(negedge clk);
    chk("abort_done_ignored", b1.busy, 0);
    chk("abort_no_tx", b1.tx_valid, 0);
    chk("abort_tx_count", tx_q.size(), 0);
    tick;

    // Long decode saturates the cycle field.
    run_txn(1'b0, 1, 70000, 8'h7F, 1, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
